mdio_responder: RTL and testbench

- PHY-side MDIO management target (Clause 22) for the Ethernet subsystem.
- Oversamples MDC/MDIO on the FPGA system clock and decodes management frames addressed to PHY_ADDR.
- Issues single-cycle read/write strobes to an external 32x16 register bank, and drives read data back onto MDIO.
- Used to emulate a PHY register map for our MDIO master, both on-board and in the Ethernet testbench.

---
 rtl/mdio_responder.sv | 173 +++++++++++++++++
 tb/tb_mdio_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mdio_responder.sv
// mdio_responder: Clause 22 MDIO target that decodes frames for PHY_ADDR into
// single-cycle register-bank strobes and drives read data back onto MDIO.
module mdio_responder #(
  parameter logic [4:0] PHY_ADDR     = 5'd1,
  parameter int         PREAMBLE_LEN = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oe,
  output logic [4:0]  reg_addr,
  output logic [15:0] reg_wr_data,
  output logic        reg_wr_strobe,
  output logic        reg_rd_strobe,
  input  logic [15:0] reg_rd_data,
  output logic        busy,
  output logic        frame_error
);
  typedef enum logic [2:0] {
    ST_PRE, ST_START, ST_HDR, ST_TA_RD, ST_DATA_RD, ST_TA_WR, ST_DATA_WR, ST_SKIP
  } state_t;

  localparam logic [5:0] PRE_MAX = 6'(PREAMBLE_LEN);

  state_t      state_q, state_d;
  logic [2:0]  mdc_sync_q;
  logic [1:0]  mdio_sync_q;
  logic [5:0]  cnt_q, cnt_d;
  logic [15:0] shift_q, shift_d;
  logic        mdio_out_q, mdio_out_d;
  logic        mdio_oe_q, mdio_oe_d;
  logic [4:0]  reg_addr_q, reg_addr_d;
  logic [15:0] reg_wr_data_q, reg_wr_data_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic        rd_strobe_q, rd_strobe_d;
  logic        rd_cap_q;
  logic        busy_q, busy_d;
  logic        frame_error_q, frame_error_d;
  logic        rise, bit_in, is_rd, is_wr, bad_op, ta_ok;
  logic [11:0] hdr;

  assign rise   = mdc_sync_q[1] & ~mdc_sync_q[2];
  assign bit_in = mdio_sync_q[1];
  assign hdr    = {shift_q[10:0], bit_in};
  assign is_rd  = hdr[11:10] == 2'b10 && hdr[9:5] == PHY_ADDR;
  assign is_wr  = hdr[11:10] == 2'b01 && hdr[9:5] == PHY_ADDR;
  assign bad_op = hdr[11] == hdr[10];
  assign ta_ok  = {shift_q[0], bit_in} == 2'b10;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_PRE;
      mdc_sync_q    <= '0;
      mdio_sync_q   <= '1;
      cnt_q         <= '0;
      shift_q       <= '0;
      mdio_out_q    <= 1'b1;
      mdio_oe_q     <= 1'b0;
      reg_addr_q    <= '0;
      reg_wr_data_q <= '0;
      wr_strobe_q   <= 1'b0;
      rd_strobe_q   <= 1'b0;
      rd_cap_q      <= 1'b0;
      busy_q        <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mdc_sync_q    <= {mdc_sync_q[1:0], mdc};
      mdio_sync_q   <= {mdio_sync_q[0], mdio_in};
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      mdio_out_q    <= mdio_out_d;
      mdio_oe_q     <= mdio_oe_d;
      reg_addr_q    <= reg_addr_d;
      reg_wr_data_q <= reg_wr_data_d;
      wr_strobe_q   <= wr_strobe_d;
      rd_strobe_q   <= rd_strobe_d;
      rd_cap_q      <= rd_strobe_q;
      busy_q        <= busy_d;
      frame_error_q <= frame_error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (rise)
      case (state_q)
        ST_PRE:     state_d = (!bit_in && cnt_q == PRE_MAX) ? ST_START : ST_PRE;
        ST_START:   state_d = bit_in ? ST_HDR : ST_PRE;
        ST_HDR:     state_d = cnt_q != 6'd11 ? ST_HDR : is_rd ? ST_TA_RD : is_wr ? ST_TA_WR : ST_SKIP;
        ST_TA_RD:   state_d = cnt_q[0] ? ST_DATA_RD : ST_TA_RD;
        ST_DATA_RD: state_d = cnt_q == 6'd15 ? ST_PRE : ST_DATA_RD;
        ST_TA_WR:   state_d = !cnt_q[0] ? ST_TA_WR : ta_ok ? ST_DATA_WR : ST_SKIP;
        ST_DATA_WR: state_d = cnt_q == 6'd15 ? ST_PRE : ST_DATA_WR;
        default:    state_d = cnt_q == 6'd1 ? ST_PRE : ST_SKIP;
      endcase
  end

  // Read data arrives the clock after the bank sees the strobe; TA gives ample time before D15.
  always_comb begin
    cnt_d         = cnt_q;
    shift_d       = rd_cap_q ? reg_rd_data : shift_q;
    mdio_out_d    = mdio_out_q;
    mdio_oe_d     = mdio_oe_q;
    reg_addr_d    = reg_addr_q;
    reg_wr_data_d = reg_wr_data_q;
    wr_strobe_d   = 1'b0;
    rd_strobe_d   = 1'b0;
    busy_d        = busy_q;
    frame_error_d = 1'b0;
    if (rise)
      case (state_q)
        ST_PRE: cnt_d = !bit_in ? 6'd0 : cnt_q == PRE_MAX ? cnt_q : cnt_q + 6'd1;
        ST_START: begin
          cnt_d         = 6'd0;
          busy_d        = bit_in;
          frame_error_d = !bit_in;
        end
        ST_HDR: begin
          shift_d = {shift_q[14:0], bit_in};
          cnt_d   = cnt_q + 6'd1;
          if (cnt_q == 6'd11) begin
            reg_addr_d    = hdr[4:0];
            rd_strobe_d   = is_rd;
            frame_error_d = bad_op;
            cnt_d         = (is_rd || is_wr) ? 6'd0 : 6'd18;
          end
        end
        ST_TA_RD: begin
          mdio_oe_d  = 1'b1;
          mdio_out_d = cnt_q[0] ? shift_q[15] : 1'b0;
          shift_d    = cnt_q[0] ? {shift_q[14:0], 1'b0} : shift_q;
          cnt_d      = cnt_q[0] ? 6'd0 : 6'd1;
        end
        ST_DATA_RD: begin
          mdio_out_d = cnt_q == 6'd15 ? 1'b1 : shift_q[15];
          mdio_oe_d  = cnt_q != 6'd15;
          shift_d    = {shift_q[14:0], 1'b0};
          cnt_d      = cnt_q == 6'd15 ? 6'd0 : cnt_q + 6'd1;
          busy_d     = cnt_q != 6'd15;
        end
        ST_TA_WR: begin
          shift_d       = {shift_q[14:0], bit_in};
          cnt_d         = !cnt_q[0] ? 6'd1 : ta_ok ? 6'd0 : 6'd16;
          frame_error_d = cnt_q[0] && !ta_ok;
        end
        ST_DATA_WR: begin
          shift_d = {shift_q[14:0], bit_in};
          cnt_d   = cnt_q == 6'd15 ? 6'd0 : cnt_q + 6'd1;
          if (cnt_q == 6'd15) begin
            reg_wr_data_d = {shift_q[14:0], bit_in};
            wr_strobe_d   = 1'b1;
            busy_d        = 1'b0;
          end
        end
        default: begin
          cnt_d  = cnt_q == 6'd1 ? 6'd0 : cnt_q - 6'd1;
          busy_d = cnt_q != 6'd1;
        end
      endcase
  end

  assign mdio_out      = mdio_out_q;
  assign mdio_oe       = mdio_oe_q;
  assign reg_addr      = reg_addr_q;
  assign reg_wr_data   = reg_wr_data_q;
  assign reg_wr_strobe = wr_strobe_q;
  assign reg_rd_strobe = rd_strobe_q;
  assign busy          = busy_q;
  assign frame_error   = frame_error_q;
endmodule

// File: tb/tb_mdio_responder.sv
// tb_mdio_responder: MDIO master + register bank model driving mdio_responder,
// with a scoreboard of expected strobes and per-frame vector checks.
module tb_mdio_responder;
  logic clock = 1'b0, reset = 1'b1, mdc = 1'b0, m_en = 1'b0, m_val = 1'b1;
  logic mdio_in, mdio_out, mdio_oe, reg_wr_strobe, reg_rd_strobe, busy, frame_error;
  logic [4:0] reg_addr;
  logic [15:0] reg_wr_data, reg_rd_data;
  logic [15:0] mem [32];

  typedef struct packed {logic wr; logic [4:0] a; logic [15:0] d;} ev_t;
  typedef struct {
    int pre; logic [1:0] op; logic [4:0] phy, ra; logic [1:0] ta; logic [15:0] data;
    logic ew, er, ee;
  } vec_t;

  ev_t  ev_log [64];
  ev_t  exp_q [$];
  vec_t vecs [9];
  int ev_cnt = 0, wr_cnt = 0, rd_cnt = 0, err_cyc = 0, oe_cyc = 0, both_cyc = 0;
  int n_pass = 0, n_total = 0, ev_rd = 0;
  logic last_busy = 1'b0;

  always #5 clock = ~clock;

  assign mdio_in = mdio_oe ? mdio_out : (m_en ? m_val : 1'b1);

  mdio_responder #(.PHY_ADDR(5'd1), .PREAMBLE_LEN(32)) dut (
    .clock(clock), .reset(reset), .mdc(mdc), .mdio_in(mdio_in),
    .mdio_out(mdio_out), .mdio_oe(mdio_oe), .reg_addr(reg_addr),
    .reg_wr_data(reg_wr_data), .reg_wr_strobe(reg_wr_strobe),
    .reg_rd_strobe(reg_rd_strobe), .reg_rd_data(reg_rd_data),
    .busy(busy), .frame_error(frame_error)
  );

  function automatic logic [15:0] preload(input int i);
    return (i == 2) ? 16'hABCD : 16'h1357 ^ 16'(i * 613);
  endfunction

  // Register bank with a registered read port: data valid the clock after the strobe.
  always @(posedge clock) begin
    if (reset) for (int i = 0; i < 32; i++) mem[i] <= preload(i);
    else if (reg_wr_strobe) mem[reg_addr] <= reg_wr_data;
    if (reg_rd_strobe) reg_rd_data <= mem[reg_addr];
  end

  always @(negedge clock) begin
    if (reg_wr_strobe) wr_cnt++;
    if (reg_rd_strobe) rd_cnt++;
    if (reg_wr_strobe && reg_rd_strobe) both_cyc++;
    if (frame_error) err_cyc++;
    if (mdio_oe) oe_cyc++;
    if ((reg_wr_strobe || reg_rd_strobe) && ev_cnt < 64) begin
      ev_log[ev_cnt] = '{reg_wr_strobe, reg_addr, reg_wr_strobe ? reg_wr_data : 16'h0};
      ev_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endtask

  task automatic mdc_bit(input logic en, input logic val, output logic s);
    m_en = en;
    m_val = val;
    repeat (8) @(negedge clock);
    s = mdio_in;
    last_busy = busy;
    mdc = 1'b1;
    repeat (8) @(negedge clock);
    mdc = 1'b0;
  endtask

  task automatic send_frame(input vec_t v, output logic [17:0] rb);
    logic s;
    logic [13:0] hdr;
    hdr = {2'b01, v.op, v.phy, v.ra};
    rb = '0;
    for (int i = 0; i < v.pre; i++) mdc_bit(1'b1, 1'b1, s);
    for (int i = 13; i >= 0; i--) mdc_bit(1'b1, hdr[i], s);
    if (v.op == 2'b10)
      for (int i = 0; i < 18; i++) begin
        mdc_bit(1'b0, 1'b1, s);
        rb = {rb[16:0], s};
      end
    else begin
      for (int i = 1; i >= 0; i--) mdc_bit(1'b1, v.ta[i], s);
      for (int i = 15; i >= 0; i--) mdc_bit(1'b1, v.data[i], s);
    end
    m_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    ev_t ev, e;
    while (ev_rd < ev_cnt) begin
      ev = ev_log[ev_rd];
      ev_rd++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL %s_unexpected: got strobe wr=%0b addr=%0d, required none", tag, ev.wr, ev.a);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_sb_kind"}, 32'(ev.wr), 32'(e.wr));
        check({tag, "_sb_addr"}, 32'(ev.a), 32'(e.a));
        if (e.wr) check({tag, "_sb_data"}, 32'(ev.d), 32'(e.d));
      end
    end
    check({tag, "_sb_pending"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    vec_t v;
    logic [17:0] rb;
    logic s;
    logic [13:0] hdr;
    logic [15:0] rd_val;
    int w0, r0, e0, o0;
    vecs[0] = '{32, 2'b01, 5'd1, 5'd4,  2'b10, 16'h1234,     1'b1, 1'b0, 1'b0};
    vecs[1] = '{32, 2'b10, 5'd1, 5'd2,  2'b10, preload(2),   1'b0, 1'b1, 1'b0};
    vecs[2] = '{32, 2'b01, 5'd3, 5'd9,  2'b10, 16'hBEEF,     1'b0, 1'b0, 1'b0};
    vecs[3] = '{20, 2'b01, 5'd1, 5'd5,  2'b10, 16'h1111,     1'b0, 1'b0, 1'b0};
    vecs[4] = '{32, 2'b01, 5'd1, 5'd5,  2'b10, 16'h0F0F,     1'b1, 1'b0, 1'b0};
    vecs[5] = '{32, 2'b01, 5'd1, 5'd6,  2'b00, 16'h2222,     1'b0, 1'b0, 1'b1};
    vecs[6] = '{32, 2'b01, 5'd1, 5'd7,  2'b10, 16'h5A5A,     1'b1, 1'b0, 1'b0};
    vecs[7] = '{32, 2'b00, 5'd1, 5'd3,  2'b10, 16'h3333,     1'b0, 1'b0, 1'b1};
    vecs[8] = '{32, 2'b10, 5'd1, 5'd31, 2'b10, preload(31),  1'b0, 1'b1, 1'b0};

    repeat (3) @(negedge clock);
    check("reset_ctrl", {mdio_oe, mdio_out, reg_wr_strobe, reg_rd_strobe, busy, frame_error}, 6'b010000);
    check("reset_regs", {reg_addr, reg_wr_data}, 21'h0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    for (int k = 0; k < 9; k++) begin
      v = vecs[k];
      w0 = wr_cnt; r0 = rd_cnt; e0 = err_cyc; o0 = oe_cyc;
      if (v.ew) exp_q.push_back('{1'b1, v.ra, v.data});
      if (v.er) exp_q.push_back('{1'b0, v.ra, 16'h0});
      send_frame(v, rb);
      repeat (12) @(negedge clock);
      check($sformatf("v%0d_wr_count", k), 32'(wr_cnt - w0), 32'(v.ew));
      check($sformatf("v%0d_rd_count", k), 32'(rd_cnt - r0), 32'(v.er));
      check($sformatf("v%0d_err_cycles", k), 32'(err_cyc - e0), 32'(v.ee));
      check($sformatf("v%0d_busy_mid", k), 32'(last_busy), 32'(v.pre >= 32));
      check($sformatf("v%0d_busy_end", k), 32'(busy), 0);
      check($sformatf("v%0d_oe_end", k), {mdio_oe, mdio_out}, 2'b01);
      if (v.op == 2'b10) check($sformatf("v%0d_rd_bits", k), 32'(rb), 32'({2'b10, v.data}));
      else check($sformatf("v%0d_oe_cycles", k), 32'(oe_cyc - o0), 0);
      drain($sformatf("v%0d", k));
    end

    // Reset while D8 of a read of reg 2 is on the wire.
    w0 = wr_cnt; r0 = rd_cnt;
    rd_val = preload(2);
    exp_q.push_back('{1'b0, 5'd2, 16'h0});
    hdr = {2'b01, 2'b10, 5'd1, 5'd2};
    for (int i = 0; i < 32; i++) mdc_bit(1'b1, 1'b1, s);
    for (int i = 13; i >= 0; i--) mdc_bit(1'b1, hdr[i], s);
    for (int i = 0; i < 9; i++) mdc_bit(1'b0, 1'b1, s);
    check("rst_d8_oe", 32'(mdio_oe), 1);
    check("rst_d8_val", 32'(mdio_out), 32'(rd_val[8]));
    reset = 1'b1;
    @(negedge clock);
    check("rst_mid_oe", 32'(mdio_oe), 0);
    check("rst_mid_busy", 32'(busy), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    check("rst_wr_count", 32'(wr_cnt - w0), 0);
    check("rst_rd_count", 32'(rd_cnt - r0), 1);
    drain("rst");

    // Back-to-back write then read of reg 0 after reset release.
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cyc;
    exp_q.push_back('{1'b1, 5'd0, 16'hFFFF});
    exp_q.push_back('{1'b0, 5'd0, 16'h0});
    v = '{32, 2'b01, 5'd1, 5'd0, 2'b10, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    send_frame(v, rb);
    v = '{32, 2'b10, 5'd1, 5'd0, 2'b10, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    send_frame(v, rb);
    repeat (12) @(negedge clock);
    check("b2b_rd_bits", 32'(rb), 32'({2'b10, 16'hFFFF}));
    check("b2b_wr_count", 32'(wr_cnt - w0), 1);
    check("b2b_rd_count", 32'(rd_cnt - r0), 1);
    check("b2b_err_cycles", 32'(err_cyc - e0), 0);
    check("b2b_oe_end", 32'(mdio_oe), 0);
    drain("b2b");

    check("strobes_together", 32'(both_cyc), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
